// File: rtl/csr_master.sv
// csr_master: single-outstanding CSR initiator; one host command -> one CSR transaction -> one completion.
// Optional abort-on-timeout is enabled by defining CSR_MASTER_TIMEOUT_EN.
module csr_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hdead_dead
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read_not_write,
  input  logic [15:0] cmd_select,
  input  logic [15:0] cmd_address,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        csr_request__valid,
  output logic        csr_request__read_not_write,
  output logic [15:0] csr_request__select,
  output logic [15:0] csr_request__address,
  output logic [31:0] csr_request__data,
  input  logic        csr_response__ack,
  input  logic        csr_response__read_data_valid,
  input  logic [31:0] csr_response__read_data
);
  localparam int unsigned SEL_W  = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    READ_WAIT = 2'd2,
    RESPOND   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                req_rnw_q, req_rnw_d;
  logic [SEL_W-1:0]    req_sel_q, req_sel_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_data_q, req_data_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                timeout_c;

`ifdef CSR_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts cycles spent waiting on the responder; held at zero while idle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == REQUEST || state_q == READ_WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign timeout_c = (state_q == REQUEST || state_q == READ_WAIT) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a responder event always takes priority over a timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cmd_valid) state_d = REQUEST;
      REQUEST: begin
        if (csr_response__ack) begin
          state_d = (req_rnw_q && !csr_response__read_data_valid) ? READ_WAIT : RESPOND;
        end else if (timeout_c) begin
          state_d = RESPOND;
        end
      end
      READ_WAIT: if (csr_response__read_data_valid || timeout_c) state_d = RESPOND;
      RESPOND:   if (rsp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Request/response datapath; everything returns to zero when the completion is taken
  always_comb begin
    req_rnw_d  = req_rnw_q;
    req_sel_d  = req_sel_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          req_rnw_d  = cmd_read_not_write;
          req_sel_d  = cmd_select;
          req_addr_d = cmd_address;
          req_data_d = cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      REQUEST: begin
        if (csr_response__ack) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = (req_rnw_q && csr_response__read_data_valid) ? csr_response__read_data : '0;
        end else if (timeout_c) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = req_rnw_q ? TIMEOUT_DATA : '0;
        end
      end
      READ_WAIT: begin
        if (csr_response__read_data_valid) begin
          rsp_data_d = csr_response__read_data;
        end else if (timeout_c) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = TIMEOUT_DATA;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          req_rnw_d  = 1'b0;
          req_sel_d  = '0;
          req_addr_d = '0;
          req_data_d = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_rnw_q  <= 1'b0;
      req_sel_q  <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      req_rnw_q  <= req_rnw_d;
      req_sel_q  <= req_sel_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    cmd_ready          = (state_q == IDLE);
    rsp_valid          = (state_q == RESPOND);
    csr_request__valid = (state_q == REQUEST);
  end

  assign csr_request__read_not_write = req_rnw_q;
  assign csr_request__select         = req_sel_q;
  assign csr_request__address        = req_addr_q;
  assign csr_request__data           = req_data_q;
  assign rsp_data                    = rsp_data_q;
  assign rsp_error                   = rsp_err_q;

endmodule
